// File: rtl/mmio_uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package mmio_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Word offsets from the register window base.
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  // STATUS register bit positions.
  localparam int unsigned ST_BUSY   = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_EMPTY  = 2;
  localparam int unsigned ST_OVF    = 3;
  localparam int unsigned ST_CNT_LO = 4;
  localparam int unsigned ST_CNT_HI = 7;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO; a push on full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (cnt != '0);
  assign do_push  = push && ((cnt != FULL_CNT) || do_pop);
  assign pop_data = mem[rd_ptr];
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign count    = cnt;

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, byte FIFO, serializer.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  input  logic        write_enable,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic        tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t state_q, state_n;
  logic [BW-1:0] baud_q, baud_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shift_q, shift_n;
  logic          tx_q, tx_n;
  logic          pop;

  logic          hit_tx, hit_status;
  logic          push_req, ovf_set, ovf_clr;
  logic          overflow_q;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word;
  logic          unused_data_bits;

  assign hit_tx     = (address_to_mem == BASE_ADDR + TXDATA_OFS);
  assign hit_status = (address_to_mem == BASE_ADDR + STATUS_OFS);
  assign hit        = hit_tx || hit_status;
  assign push_req   = write_enable && hit_tx;
  assign ovf_set    = push_req && fifo_full && !pop;
  assign ovf_clr    = write_enable && hit_status && data_to_mem[ST_OVF];
  assign tx         = tx_q;
  assign unused_data_bits = ^data_to_mem[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (data_to_mem[7:0]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow flag; a clear in the same cycle as a new overflow wins.
  always_ff @(posedge clk) begin
    if (reset || ovf_clr) begin
      overflow_q <= 1'b0;
    end else if (ovf_set) begin
      overflow_q <= 1'b1;
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_word                       = '0;
    status_word[ST_BUSY]              = (state_q != IDLE);
    status_word[ST_FULL]              = fifo_full;
    status_word[ST_EMPTY]             = fifo_empty;
    status_word[ST_OVF]               = overflow_q;
    status_word[ST_CNT_HI:ST_CNT_LO]  = 4'(fifo_count);
  end

  // Register read mux; TXDATA and unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    if (hit_status) begin
      rd_data = status_word;
    end
  end

  // Transmit state, counters, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
    end
  end

  // Next-state logic; tx_n is the line level for the coming cycle so tx stays glitch-free.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_head;
          baud_n  = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shift_q[0];
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_q + 1'b1;
            tx_n  = shift_q[1];
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_head;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores push expected bytes, a line monitor decodes frames.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic        write_enable;
  logic [31:0] rd_data;
  logic        hit;
  logic        tx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned rst_cnt  = 0;
  logic [7:0]  exp_q [$];

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_0400),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .write_enable   (write_enable),
    .rd_data        (rd_data),
    .hit            (hit),
    .tx             (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset epochs let the monitor discard a frame cut short by reset.
  always @(posedge clk) if (reset) rst_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one store at a negedge; the following posedge samples it.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    address_to_mem = addr;
    data_to_mem    = data;
    write_enable   = 1'b1;
    @(negedge clk);
    write_enable   = 1'b0;
    address_to_mem = 32'h0;
    data_to_mem    = 32'h0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    write_enable   = 1'b0;
    address_to_mem = 32'h0000_0404;
    #1;
    v = rd_data;
    address_to_mem = 32'h0;
  endtask

  // Line monitor: decodes each frame at bit centres and compares against the scoreboard.
  initial begin : monitor
    logic [7:0]  b;
    logic        s0, s1;
    int unsigned epoch;
    logic [7:0]  e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        epoch = rst_cnt;
        repeat (2) @(negedge clk);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx;
        end
        repeat (4) @(negedge clk);
        s1 = tx;
        if (epoch == rst_cnt) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {22'b0, s1, b, s0}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("frame", {22'b0, s1, b, s0}, {22'b0, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] st;
    logic [9:0]  pat;
    int unsigned cnt;
    logic        done;

    reset = 1'b1;
    address_to_mem = '0;
    data_to_mem    = '0;
    write_enable   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and 20 idle cycles.
    for (int i = 0; i < 20; i++) begin
      check("idle_tx", {31'b0, tx}, 32'h1);
      @(negedge clk);
    end
    rd_status(st);
    check("reset_status", st, 32'h0000_0004);
    address_to_mem = 32'h0000_0400;
    #1;
    check("hit_txdata", {31'b0, hit}, 32'h1);
    check("rd_txdata", rd_data, 32'h0);
    address_to_mem = 32'h0000_0404;
    #1;
    check("hit_status", {31'b0, hit}, 32'h1);
    address_to_mem = 32'h0;
    @(negedge clk);

    // Single byte 0x55: start latency and mid-bit levels.
    exp_q.push_back(8'h55);
    store(32'h0000_0400, 32'hFFFF_FF55);
    check("tx_before_start", {31'b0, tx}, 32'h1);
    @(negedge clk);
    check("tx_start_edge", {31'b0, tx}, 32'h0);
    rd_status(st);
    check("status_busy", st, 32'h0000_0005);
    repeat (2) @(negedge clk);
    pat = 10'b10_1010_1010;  // stop, d7..d0, start (bit 0 sent first)
    for (int i = 0; i < 10; i++) begin
      check("bit_55", {31'b0, tx}, {31'b0, pat[i]});
      repeat (4) @(negedge clk);
    end
    rd_status(st);
    check("status_after_frame", st, 32'h0000_0004);
    @(negedge clk);

    // Three consecutive stores: contiguous frames, busy never drops.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    store(32'h0000_0400, 32'h41);
    store(32'h0000_0400, 32'h42);
    store(32'h0000_0400, 32'h43);
    // Now 1.5 cycles into the first frame; 119 busy samples remain before idle.
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      rd_status(st);
      if (st[0]) cnt++;
      else done = 1'b1;
      @(negedge clk);
    end
    check("busy_run_3frames", cnt, 32'd119);
    repeat (5) @(negedge clk);

    // Ten stores with FSM idle: one popped, eight queued, one dropped.
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(8'h60 + i));
      store(32'h0000_0400, 32'(8'h60 + i));
    end
    rd_status(st);
    check("status_overflow", st, 32'h0000_008B);
    @(negedge clk);
    store(32'h0000_0404, 32'h0000_0008);
    rd_status(st);
    check("status_ovf_cleared", st, 32'h0000_0083);
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      rd_status(st);
      if (st == 32'h0000_0004) done = 1'b1;
    end
    check("drain_done", {31'b0, done}, 32'h1);
    repeat (5) @(negedge clk);
    check("queue_after_drain", exp_q.size(), 32'd0);

    // Reset mid-DATA with three bytes queued; nothing more may appear.
    store(32'h0000_0400, 32'h11);
    store(32'h0000_0400, 32'h22);
    store(32'h0000_0400, 32'h33);
    store(32'h0000_0400, 32'h44);
    repeat (10) @(negedge clk);
    rd_status(st);
    check("status_pre_reset", st, 32'h0000_0031);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("tx_after_reset", {31'b0, tx}, 32'h1);
    rd_status(st);
    check("status_after_reset", st, 32'h0000_0004);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    check("no_frames_after_reset", cnt, 32'd0);

    // Stores outside the window are ignored.
    begin
      logic [31:0] bad [3];
      bad[0] = 32'h0000_03FC;
      bad[1] = 32'h0000_0408;
      bad[2] = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
        address_to_mem = bad[i];
        data_to_mem    = 32'h0000_00A5;
        write_enable   = 1'b1;
        #1;
        check("miss_hit", {31'b0, hit}, 32'h0);
        check("miss_rd", rd_data, 32'h0);
        @(negedge clk);
        write_enable = 1'b0;
      end
    end
    rd_status(st);
    check("status_after_miss", st, 32'h0000_0004);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    check("tx_idle_after_miss", cnt, 32'd0);
    check("queue_final", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor data bus: it consumes the same `address_to_mem` / `data_to_mem` / `write_enable` signals that feed data memory. Stores to its register window queue bytes into a small FIFO. The block serializes those bytes as 8N1 frames on `tx`. A combinational status read path lets software poll for room before storing, and the bench can observe output bytes without inspecting RAM.

## Interface
- `BASE_ADDR`, 32'h0000_0400: word-aligned base of the register window. It lies outside the 64-word data RAM.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, 8: number of FIFO entries. Must be a power of two, 2..8.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `address_to_mem` input 32: processor data address.
- `data_to_mem` input 32: processor store data.
- `write_enable` input 1: processor store strobe.
- `rd_data` output 32: combinational register read value. Zero when `hit` = 0.
- `hit` output 1: combinational; asserted when `address_to_mem` is BASE+0 or BASE+4.
- `tx` output 1: serial line, idle high.

## Operation
- Register map, word offsets. Any other address gives `hit` = 0 and is ignored.
  - BASE+0 TXDATA, write-only. A store pushes `data_to_mem[7:0]`; bits [31:8] are ignored. Reads return 0.
  - BASE+4 STATUS:
    - [0] busy: FSM not in IDLE.
    - [1] full.
    - [2] empty.
    - [3] overflow (sticky).
    - [7:4] FIFO count.
    - [31:8] read as 0.
  - Writing STATUS with `data_to_mem[3]` = 1 clears overflow. All other STATUS bits ignore writes.
- Push: `write_enable` && address == BASE+0.
  - If not full, the byte is accepted.
  - If full and no pop occurs that cycle, the byte is dropped and overflow is set.
  - If full and a pop occurs in the same cycle, the push is accepted and the count is unchanged.
- Overflow-set and overflow-clear in the same cycle: clear wins.
- FSM states: IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT−1) run alongside it.
  - IDLE: `tx` = 1. If FIFO is non-empty: pop head into the shift register, go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx` = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; shift right after each bit. After 8 bits, go to STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles.
    - On its last cycle, if FIFO is non-empty: pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- `tx` is registered, driven from state and shift register. No glitches.
- Reset values: `tx` = 1, state IDLE, FIFO empty (count 0), overflow 0, counters 0. `rd_data` / `hit` are combinational and follow the inputs.
- Reset mid-frame: the frame is aborted, `tx` = 1 after the reset edge, and queued bytes are discarded.

## Timing
- A push sampled at edge n is counted at edge n. STATUS reads the new count in cycle n+1.
- With FSM idle: pop and IDLE→START at edge n+1. `tx` falls after edge n+1, giving 1 cycle latency from store to start bit.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- Back-to-back bytes: the next start bit immediately follows the stop bit's final cycle.
- Pops happen only on IDLE→START or STOP→START, so there is at most one pop per frame.
- Count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

## Structure
- Package `mmio_uart_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, STOP).
  - Register offsets `TXDATA_OFS` = 0 and `STATUS_OFS` = 4.
  - STATUS bit-index constants.
- Sub-module `sync_fifo`: parameterised width and depth, push/pop/full/empty/count. Push is accepted on full when a pop occurs in the same cycle.
- Top level `mmio_uart_tx`: address decode, STATUS mux, overflow flag, transmit FSM and counters.

## Test plan
- Reset, then idle for 20 cycles. Expect `tx` = 1 throughout and STATUS = 32'h0000_0004.
- Store 32'hFFFF_FF55 to 0x400. Expect `tx` low 1 cycle later. Sample mid-bit every 4 cycles and expect 0,1,0,1,0,1,0,1,0,1. Frame is 40 cycles, then STATUS busy = 0.
- Store 0x41, 0x42, 0x43 on consecutive cycles. Expect three contiguous frames (120 cycles, no idle gap), decoded as 0x41, 0x42, 0x43 in order.
- Store 10 bytes back-to-back with FSM idle. Expect:
  - one byte popped;
  - 8 queued, 1 dropped;
  - STATUS = 32'h0000_008B (count 8, overflow, full, busy).
  - Then store 32'h8 to 0x404 and expect overflow cleared.
- Assert `reset` mid-DATA of a frame with 3 bytes queued. Expect `tx` = 1 after the edge, STATUS = 32'h4, and no further frames.
- Store to 0x3FC, 0x408 and 0x0. Expect `hit` = 0, no FIFO change, and `tx` idle.
